gray_mem_arb: RTL and testbench

Arbiter that shares the single read port of the gray image memory between two requesters: the LBP engine (port 0) and a second reader (port 1, e.g. a host readback or statistics unit). It grants at most one read per cycle and keeps the current owner for a bounded burst, so the engine's 3- and 9-pixel fetch groups stay contiguous. It returns read data to the issuing port with a fixed latency, and sits between the requesters and the memory model.

---
 rtl/gray_mem_arb_pkg.sv | 16 +
 rtl/gray_mem_arb_rd_tag_pipe.sv | 35 +++
 rtl/gray_mem_arb.sv | 141 ++++++++++++++
 tb/tb_gray_mem_arb.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_mem_arb_pkg.sv
// Shared definitions for the gray image memory arbiter and its sibling controllers.
// Holds the owner FSM encoding, the image geometry and the default bus widths.
package gray_mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   localparam int IMG_W   = 128;
   localparam int IMG_PIX = IMG_W * IMG_W;
   localparam int DEF_AW  = 14;
   localparam int DEF_DW  = 8;

endpackage

// File: rtl/gray_mem_arb_rd_tag_pipe.sv
// Fixed-latency tag pipe: remembers which port issued each memory read so the
// returning data can be steered back to it after DEPTH cycles.
module rd_tag_pipe #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic in_valid,
   input  logic in_port,
   output logic out_valid,
   output logic out_port
);

   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] port_q;

   // Reset clears every stage so reads issued before reset never return.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         port_q  <= '0;
      end else begin
         valid_q[0] <= in_valid;
         port_q[0]  <= in_port;
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            port_q[i]  <= port_q[i-1];
         end
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_port  = port_q[DEPTH-1];

endmodule

// File: rtl/gray_mem_arb.sv
// Two-port read arbiter in front of the gray image memory. Keeps the current
// owner for up to MAX_BURST grants and returns data MEM_LAT+1 cycles after grant.
module gray_mem_arb
   import gray_mem_arb_pkg::*;
#(
   parameter int AW        = DEF_AW,
   parameter int DW        = DEF_DW,
   parameter int MEM_LAT   = 1,
   parameter int MAX_BURST = 9
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic [AW-1:0] addr0,
   input  logic          req1,
   input  logic [AW-1:0] addr1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic [DW-1:0] rdata0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata1,
   output logic          mem_en,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_rdata
);

   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] MAX_C = CW'(MAX_BURST);
   localparam logic [CW-1:0] ONE_C = CW'(1);

   arb_state_t    state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          last;
   logic          tag_valid, tag_port;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         last  <= 1'b1;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (gnt0)
            last <= 1'b0;
         else if (gnt1)
            last <= 1'b1;
      end
   end

   // The owner keeps the port until its burst saturates while the other side waits.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      case (state)
         IDLE: begin
            if ((req0 && req1 && last) || (req0 && !req1)) begin
               gnt0    = 1'b1;
               state_n = OWN0;
               cnt_n   = ONE_C;
            end else if (req1) begin
               gnt1    = 1'b1;
               state_n = OWN1;
               cnt_n   = ONE_C;
            end
         end
         OWN0: begin
            if (req0 && (cnt < MAX_C || !req1)) begin
               gnt0  = 1'b1;
               cnt_n = (cnt < MAX_C) ? cnt + ONE_C : MAX_C;
            end else if (req1) begin
               gnt1    = 1'b1;
               state_n = OWN1;
               cnt_n   = ONE_C;
            end else begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         end
         OWN1: begin
            if (req1 && (cnt < MAX_C || !req0)) begin
               gnt1  = 1'b1;
               cnt_n = (cnt < MAX_C) ? cnt + ONE_C : MAX_C;
            end else if (req0) begin
               gnt0    = 1'b1;
               state_n = OWN0;
               cnt_n   = ONE_C;
            end else begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_comb begin
      mem_addr = '0;
      if (gnt0)
         mem_addr = addr0;
      else if (gnt1)
         mem_addr = addr1;
   end

   assign mem_en = gnt0 | gnt1;

   rd_tag_pipe #(
      .DEPTH(MEM_LAT)
   ) u_tag_pipe (
      .clk      (clk),
      .reset    (reset),
      .in_valid (mem_en),
      .in_port  (gnt1),
      .out_valid(tag_valid),
      .out_port (tag_port)
   );

   // The exiting tag coincides with valid memory data; register it to both ports.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rdata0  <= '0;
         rdata1  <= '0;
      end else begin
         rvalid0 <= tag_valid & ~tag_port;
         rvalid1 <= tag_valid & tag_port;
         if (tag_valid) begin
            rdata0 <= mem_rdata;
            rdata1 <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_gray_mem_arb.sv
// Self-checking bench for gray_mem_arb: directed vector table, corner sequences
// and randomized traffic compared against a behavioural arbitration/latency model.
module tb_gray_mem_arb;

   localparam int AW        = 14;
   localparam int DW        = 8;
   localparam int MEM_LAT   = 3;
   localparam int MAX_BURST = 9;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0, req1;
   logic [AW-1:0] addr0, addr1;
   logic          gnt0, gnt1;
   logic          rvalid0, rvalid1;
   logic [DW-1:0] rdata0, rdata1;
   logic          mem_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata;

   gray_mem_arb #(
      .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .MAX_BURST(MAX_BURST)
   ) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
      .gnt0(gnt0), .gnt1(gnt1),
      .rvalid0(rvalid0), .rdata0(rdata0), .rvalid1(rvalid1), .rdata1(rdata1),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: returns the low address byte MEM_LAT cycles after mem_en.
   logic [DW-1:0] mpipe [MEM_LAT];
   always @(posedge clk) begin
      mpipe[0] <= mem_en ? mem_addr[7:0] : 8'h00;
      for (int i = 1; i < MEM_LAT; i++) mpipe[i] <= mpipe[i-1];
   end
   assign mem_rdata = mpipe[MEM_LAT-1];

   typedef struct {
      int port;
      int data;
      int due;
   } rd_t;

   typedef struct {
      logic          r0;
      logic [AW-1:0] a0;
      logic          r1;
      logic [AW-1:0] a1;
      logic          eg0;
      logic          eg1;
   } vec_t;

   rd_t  sb[$];
   vec_t tbl[12];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   m_owner, m_cnt, m_last;

   task automatic checkOutput(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Arbitration rules: returns the port that should be granted, -1 for none.
   function automatic int model_grant(input logic r0, input logic r1);
      int ep;
      int o;
      logic ro, rx;
      ep = -1;
      if (m_owner < 0) begin
         if (r0 && r1) ep = 1 - m_last;
         else if (r0)  ep = 0;
         else if (r1)  ep = 1;
         if (ep >= 0) begin
            m_owner = ep;
            m_cnt   = 1;
         end
      end else begin
         o  = m_owner;
         ro = (o == 0) ? r0 : r1;
         rx = (o == 0) ? r1 : r0;
         if (ro && (m_cnt < MAX_BURST || !rx)) begin
            ep    = o;
            m_cnt = (m_cnt + 1 > MAX_BURST) ? MAX_BURST : m_cnt + 1;
         end else if (rx) begin
            ep      = 1 - o;
            m_owner = ep;
            m_cnt   = 1;
         end else begin
            m_owner = -1;
            m_cnt   = 0;
         end
      end
      if (ep >= 0) m_last = ep;
      return ep;
   endfunction

   task automatic applyStimulus(input logic r0, input logic [AW-1:0] a0,
                                input logic r1, input logic [AW-1:0] a1,
                                output logic g0, output logic g1);
      int   ep, ea, ed;
      logic ev0, ev1;
      rd_t  e;
      req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
      #4;
      ep = model_grant(r0, r1);
      ea = (ep == 0) ? int'(a0) : (ep == 1) ? int'(a1) : 0;
      checkOutput("gnt0", int'(gnt0), int'(ep == 0));
      checkOutput("gnt1", int'(gnt1), int'(ep == 1));
      checkOutput("mem_en", int'(mem_en), int'(ep >= 0));
      checkOutput("mem_addr", int'(mem_addr), ea);
      if (ep >= 0) sb.push_back('{ep, ea & 255, cyc + MEM_LAT + 1});
      ev0 = 1'b0; ev1 = 1'b0; ed = 0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e   = sb.pop_front();
         ev0 = (e.port == 0);
         ev1 = (e.port == 1);
         ed  = e.data;
      end
      checkOutput("rvalid0", int'(rvalid0), int'(ev0));
      checkOutput("rvalid1", int'(rvalid1), int'(ev1));
      if (ev0) checkOutput("rdata0", int'(rdata0), ed);
      if (ev1) checkOutput("rdata1", int'(rdata1), ed);
      g0 = gnt0;
      g1 = gnt1;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // One reset cycle with reset-value checks; drops all in-flight reads.
   task automatic do_reset();
      reset = 1'b1;
      req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
      #4;
      checkOutput("rst_rvalid0", int'(rvalid0), 0);
      checkOutput("rst_rvalid1", int'(rvalid1), 0);
      checkOutput("rst_rdata0", int'(rdata0), 0);
      checkOutput("rst_rdata1", int'(rdata1), 0);
      checkOutput("rst_gnt", int'({gnt1, gnt0}), 0);
      checkOutput("rst_mem_en", int'(mem_en), 0);
      checkOutput("rst_mem_addr", int'(mem_addr), 0);
      @(posedge clk);
      #1;
      reset   = 1'b0;
      m_owner = -1;
      m_cnt   = 0;
      m_last  = 1;
      sb.delete();
      cyc++;
   endtask

   task automatic idle(input int n);
      logic g0, g1;
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, g0, g1);
   endtask

   initial begin
      logic          g0, g1;
      logic          rr0, rr1;
      logic [AW-1:0] ra0, ra1;
      logic [AW-1:0] c0, c1;
      int            exp_port;

      tbl[0]  = '{1'b1, 14'h100, 1'b0, 14'h200, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 14'h101, 1'b1, 14'h201, 1'b1, 1'b0};
      tbl[2]  = '{1'b1, 14'h102, 1'b1, 14'h201, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 14'h000, 1'b1, 14'h201, 1'b0, 1'b1};
      tbl[4]  = '{1'b0, 14'h000, 1'b1, 14'h202, 1'b0, 1'b1};
      tbl[5]  = '{1'b0, 14'h000, 1'b0, 14'h000, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 14'h000, 1'b1, 14'h203, 1'b0, 1'b1};
      tbl[7]  = '{1'b1, 14'h103, 1'b1, 14'h204, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 14'h103, 1'b0, 14'h000, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 14'h000, 1'b0, 14'h000, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 14'h104, 1'b1, 14'h205, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 14'h000, 1'b0, 14'h000, 1'b0, 1'b0};

      do_reset();
      for (int i = 0; i < 12; i++) begin
         applyStimulus(tbl[i].r0, tbl[i].a0, tbl[i].r1, tbl[i].a1, g0, g1);
         checkOutput($sformatf("vec%0d_gnt", i), int'({g1, g0}), int'({tbl[i].eg1, tbl[i].eg0}));
      end
      idle(MEM_LAT + 2);

      // Port 0 alone, nine back-to-back reads at addresses 0..8.
      do_reset();
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b1, AW'(i), 1'b0, '0, g0, g1);
         checkOutput("p0_only_gnt", int'(g0), 1);
      end
      idle(MEM_LAT + 3);

      // Both ports saturated from reset: 9 x P0, 9 x P1, 9 x P0.
      do_reset();
      c0 = 14'h0010; c1 = 14'h0080;
      for (int i = 0; i < 27; i++) begin
         exp_port = ((i / MAX_BURST) % 2 == 0) ? 0 : 1;
         applyStimulus(1'b1, c0, 1'b1, c1, g0, g1);
         checkOutput("burst_seq", g1 ? 1 : (g0 ? 0 : -1), exp_port);
         if (g0) c0++;
         if (g1) c1++;
      end
      idle(MEM_LAT + 2);

      // Lone port 1 saturates its count, then port 0 arrives and wins at once.
      do_reset();
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, 1'b1, AW'(32 + i), g0, g1);
      applyStimulus(1'b1, 14'h0077, 1'b1, 14'h0099, g0, g1);
      checkOutput("sat_switch_gnt0", int'(g0), 1);
      idle(MEM_LAT + 2);

      // Alternating single grants P0, P1, P0.
      do_reset();
      applyStimulus(1'b1, 14'h0011, 1'b0, '0, g0, g1);
      applyStimulus(1'b0, '0, 1'b1, 14'h0022, g0, g1);
      checkOutput("alt_gnt1", int'(g1), 1);
      applyStimulus(1'b1, 14'h0033, 1'b0, '0, g0, g1);
      idle(MEM_LAT + 3);

      // Reset with two reads in flight; the next request is served normally.
      do_reset();
      applyStimulus(1'b1, 14'h0005, 1'b0, '0, g0, g1);
      applyStimulus(1'b0, '0, 1'b1, 14'h0006, g0, g1);
      do_reset();
      applyStimulus(1'b1, 14'h0007, 1'b0, '0, g0, g1);
      checkOutput("post_rst_gnt0", int'(g0), 1);
      idle(MEM_LAT + 3);

      // Randomized traffic: requests held until granted, address may move meanwhile.
      do_reset();
      rr0 = 1'b0; rr1 = 1'b0; ra0 = '0; ra1 = '0;
      for (int i = 0; i < 400; i++) begin
         if (!rr0) begin
            rr0 = ($urandom_range(0, 1) == 1);
            ra0 = AW'($urandom_range(0, 16383));
         end else if ($urandom_range(0, 3) == 0) begin
            ra0 = AW'($urandom_range(0, 16383));
         end
         if (!rr1) begin
            rr1 = ($urandom_range(0, 1) == 1);
            ra1 = AW'($urandom_range(0, 16383));
         end else if ($urandom_range(0, 3) == 0) begin
            ra1 = AW'($urandom_range(0, 16383));
         end
         applyStimulus(rr0, ra0, rr1, ra1, g0, g1);
         if (g0) begin
            rr0 = ($urandom_range(0, 3) != 0);
            ra0 = AW'($urandom_range(0, 16383));
         end
         if (g1) begin
            rr1 = ($urandom_range(0, 3) != 0);
            ra1 = AW'($urandom_range(0, 16383));
         end
      end
      idle(MEM_LAT + 3);
      checkOutput("scoreboard_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
